// File: rtl/two_bit_mult_sequencer.sv
// Splits an N-bit multiplier into LSB-first masks of at most two set bits,
// drives them to a two-bit multiplier and accumulates the partial products.
module two_bit_mult_sequencer #(
  parameter int N = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [15:0]   in_a,
  input  logic [N-1:0]  in_b,
  output logic          mul_vld,
  output logic [15:0]   mul_a,
  output logic [N-1:0]  mul_b,
  input  logic [31:0]   mul_c,
  input  logic          mul_result_vld,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_product
);

  // state | meaning
  // IDLE  | waiting for operands, in_ready high
  // RUN   | issuing masks, one per accepted partial product
  // DONE  | holding the product until out_ready
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   a_q;
  logic [N-1:0]  rem_q;
  logic [31:0]   acc_q;

  logic [N-1:0]  low_bit;
  logic [N-1:0]  rem_hi;
  logic [N-1:0]  second_bit;
  logic [N-1:0]  mask;
  logic [N-1:0]  rem_next;
  logic          accept;
  logic          step;

  // Two's-complement trick isolates the lowest set bit.
  always_comb begin
    low_bit    = rem_q & (~rem_q + {{(N-1){1'b0}}, 1'b1});
    rem_hi     = rem_q & ~low_bit;
    second_bit = rem_hi & (~rem_hi + {{(N-1){1'b0}}, 1'b1});
    mask       = low_bit | second_bit;
    rem_next   = rem_q & ~mask;
  end

  assign accept = (state_q == IDLE) && in_valid;
  assign step   = (state_q == RUN) && mul_result_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = (in_b != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (mul_result_vld && (rem_next == '0)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready    = 1'b0;
    mul_vld     = 1'b0;
    mul_a       = '0;
    mul_b       = '0;
    out_valid   = 1'b0;
    out_product = '0;
    case (state_q)
      IDLE: in_ready = 1'b1;
      RUN: begin
        mul_vld = 1'b1;
        mul_a   = a_q;
        mul_b   = mask;
      end
      DONE: begin
        out_valid   = 1'b1;
        out_product = acc_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      rem_q <= '0;
      acc_q <= '0;
    end else if (accept) begin
      a_q   <= in_a;
      rem_q <= in_b;
      acc_q <= '0;
    end else if (step) begin
      rem_q <= rem_next;
      acc_q <= acc_q + mul_c;
    end
  end

endmodule

// File: tb/tb_two_bit_mult_sequencer.sv
// Directed bench for two_bit_mult_sequencer with a behavioural combinational
// two-bit multiplier on the downstream side.
module tb_two_bit_mult_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        mul_vld;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic [31:0] mul_c;
  logic        mul_result_vld;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_product;
  logic        stall;

  int n_cmp = 0;
  int n_err = 0;

  two_bit_mult_sequencer #(.N(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_vld(mul_vld), .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c),
    .mul_result_vld(mul_result_vld),
    .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product)
  );

  always #5 clk = ~clk;

  assign mul_c          = {16'h0, mul_a} * {16'h0, mul_b};
  assign mul_result_vld = mul_vld & ~stall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Accept at the next posedge T, then step through cycles T+1.. at negedges.
  task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] masks [8], input int nm, input logic [31:0] prod);
    @(negedge clk);
    check({name, " in_ready idle"}, {31'h0, in_ready}, 32'h1);
    in_valid = 1'b1; in_a = a; in_b = b;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < nm; i++) begin
      check($sformatf("%s mul_vld[%0d]", name, i), {31'h0, mul_vld}, 32'h1);
      check($sformatf("%s mul_b[%0d]", name, i), {16'h0, mul_b}, {16'h0, masks[i]});
      check($sformatf("%s mul_a[%0d]", name, i), {16'h0, mul_a}, {16'h0, a});
      check($sformatf("%s in_ready run[%0d]", name, i), {31'h0, in_ready}, 32'h0);
      @(negedge clk);
    end
    check({name, " mul_vld done"}, {31'h0, mul_vld}, 32'h0);
    check({name, " out_valid"}, {31'h0, out_valid}, 32'h1);
    check({name, " out_product"}, out_product, prod);
    check({name, " in_ready done"}, {31'h0, in_ready}, 32'h0);
    @(negedge clk);
    check({name, " out_valid after"}, {31'h0, out_valid}, 32'h0);
    check({name, " in_ready after"}, {31'h0, in_ready}, 32'h1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    out_ready = 1'b1; stall = 1'b0;
    #12;
    check("rst in_ready", {31'h0, in_ready}, 32'h1);
    check("rst mul_vld", {31'h0, mul_vld}, 32'h0);
    check("rst mul_a", {16'h0, mul_a}, 32'h0);
    check("rst mul_b", {16'h0, mul_b}, 32'h0);
    check("rst out_valid", {31'h0, out_valid}, 32'h0);
    check("rst out_product", out_product, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("zero", 16'h1234, 16'h0000, '{default: 16'h0}, 0, 32'h0);
    run_op("full", 16'hFFFF, 16'hFFFF,
           '{16'h0003, 16'h000C, 16'h0030, 16'h00C0, 16'h0300, 16'h0C00, 16'h3000, 16'hC000},
           8, 32'hFFFE0001);
    run_op("sparse", 16'h0003, 16'h8001, '{0: 16'h8001, default: 16'h0}, 1, 32'h00018003);
    run_op("single", 16'h00AB, 16'h0100, '{0: 16'h0100, default: 16'h0}, 1, 32'h0000AB00);
    run_op("odd", 16'h0005, 16'h0007, '{0: 16'h0003, 1: 16'h0004, default: 16'h0}, 2, 32'h23);

    // Stall on the first mask for 3 cycles, then hold off out_ready for 4 cycles.
    @(negedge clk);
    stall = 1'b1; in_valid = 1'b1; in_a = 16'h5; in_b = 16'h7;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("stall mul_vld[%0d]", i), {31'h0, mul_vld}, 32'h1);
      check($sformatf("stall mul_b[%0d]", i), {16'h0, mul_b}, 32'h3);
      check($sformatf("stall mul_a[%0d]", i), {16'h0, mul_a}, 32'h5);
      check($sformatf("stall in_ready[%0d]", i), {31'h0, in_ready}, 32'h0);
      @(negedge clk);
    end
    stall = 1'b0;
    check("stall mask0 released", {16'h0, mul_b}, 32'h3);
    @(negedge clk);
    check("stall mask1", {16'h0, mul_b}, 32'h4);
    out_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp out_valid[%0d]", i), {31'h0, out_valid}, 32'h1);
      check($sformatf("bp out_product[%0d]", i), out_product, 32'h23);
      check($sformatf("bp in_ready[%0d]", i), {31'h0, in_ready}, 32'h0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    check("bp release out_valid", {31'h0, out_valid}, 32'h1);
    check("bp release in_ready", {31'h0, in_ready}, 32'h0);
    @(negedge clk);
    check("bp idle in_ready", {31'h0, in_ready}, 32'h1);
    check("bp idle out_valid", {31'h0, out_valid}, 32'h0);

    // Reset pulse in the middle of a long run.
    @(negedge clk);
    in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'hFFFF;
    @(negedge clk);
    in_valid = 1'b0;
    check("mid mul_vld before", {31'h0, mul_vld}, 32'h1);
    @(negedge clk);
    check("mid mul_b before", {16'h0, mul_b}, 32'h000C);
    rst_n = 1'b0;
    #1;
    check("mid mul_vld", {31'h0, mul_vld}, 32'h0);
    check("mid out_valid", {31'h0, out_valid}, 32'h0);
    check("mid in_ready", {31'h0, in_ready}, 32'h1);
    check("mid mul_b", {16'h0, mul_b}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    check("mid no out_valid", {31'h0, out_valid}, 32'h0);
    run_op("post_rst", 16'h0002, 16'h0003, '{0: 16'h0003, default: 16'h0}, 1, 32'h6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
